// File: rtl/alu_lane_split_pkg.sv
// rtl/alu_lane_split_pkg.sv - shared sizing helpers, FSM state type and packet-activity function
package alu_lane_split_pkg;

    // Widest warp the activity helper is written for; packets are derived from a zero-extended mask.
    localparam int MAX_THREADS = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    function automatic int calc_num_pkts(input int num_threads, input int num_lanes);
        return num_threads / num_lanes;
    endfunction

    // A single-packet warp still needs a one-bit pid field.
    function automatic int calc_pid_width(input int num_threads, input int num_lanes);
        int n;
        n = num_threads / num_lanes;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit p of the result is set when any lane of packet p is active in the thread mask.
    function automatic logic [MAX_THREADS-1:0] pkt_active(input logic [MAX_THREADS-1:0] tmask,
                                                          input int num_threads,
                                                          input int num_lanes);
        logic [MAX_THREADS-1:0] act;
        act = '0;
        for (int t = 0; t < MAX_THREADS; t++) begin
            if (t < num_threads) begin
                act[t / num_lanes] = act[t / num_lanes] | tmask[t];
            end
        end
        return act;
    endfunction

endpackage

// File: rtl/alu_lane_split_if.sv
// rtl/alu_lane_split_if.sv - warp request side and packet side of the lane splitter
interface alu_lane_split_if #(
    parameter int NUM_THREADS = 8,
    parameter int NUM_LANES   = 2,
    parameter int HDR_W       = 64,
    parameter int XLEN        = 32
);
    localparam int PID_WIDTH = alu_lane_split_pkg::calc_pid_width(NUM_THREADS, NUM_LANES);

    logic                         in_valid;
    logic                         in_ready;
    logic [HDR_W-1:0]             in_hdr;
    logic [NUM_THREADS-1:0]       in_tmask;
    logic [NUM_THREADS*XLEN-1:0]  in_rs1_data;
    logic [NUM_THREADS*XLEN-1:0]  in_rs2_data;
    logic [NUM_THREADS*XLEN-1:0]  in_rs3_data;

    logic                         out_valid;
    logic                         out_ready;
    logic [HDR_W-1:0]             out_hdr;
    logic [NUM_LANES-1:0]         out_tmask;
    logic [NUM_LANES*XLEN-1:0]    out_rs1_data;
    logic [NUM_LANES*XLEN-1:0]    out_rs2_data;
    logic [NUM_LANES*XLEN-1:0]    out_rs3_data;
    logic [PID_WIDTH-1:0]         out_pid;
    logic                         out_sop;
    logic                         out_eop;

    // The splitter itself.
    modport slave (
        input  in_valid, in_hdr, in_tmask, in_rs1_data, in_rs2_data, in_rs3_data, out_ready,
        output in_ready, out_valid, out_hdr, out_tmask, out_rs1_data, out_rs2_data, out_rs3_data,
               out_pid, out_sop, out_eop
    );

    // Whatever feeds warps in and consumes packets out.
    modport master (
        output in_valid, in_hdr, in_tmask, in_rs1_data, in_rs2_data, in_rs3_data, out_ready,
        input  in_ready, out_valid, out_hdr, out_tmask, out_rs1_data, out_rs2_data, out_rs3_data,
               out_pid, out_sop, out_eop
    );
endinterface

// File: rtl/alu_lane_split_prio_enc.sv
// rtl/alu_lane_split_prio_enc.sv - lowest-index-first priority encoder
module alu_lane_split_prio_enc #(
    parameter int N  = 4,
    parameter int LN = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  data_in,
    output logic [LN-1:0] index,
    output logic          valid_out
);

    // Scan from the top so the lowest set bit is the one left standing.
    always_comb begin
        index     = '0;
        valid_out = |data_in;
        for (int i = N - 1; i >= 0; i--) begin
            if (data_in[i]) begin
                index = LN'(i);
            end
        end
    end

endmodule

// File: rtl/alu_lane_split.sv
// rtl/alu_lane_split.sv - serialises a warp request into lane packets; ALU_SPLIT_SKIP_EMPTY_EN skips empty packets
module alu_lane_split
    import alu_lane_split_pkg::*;
#(
    parameter int NUM_THREADS = 8,
    parameter int NUM_LANES   = 2,
    parameter int HDR_W       = 64,
    parameter int XLEN        = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_lane_split_if.slave   bus
);

    localparam int NUM_PKTS  = calc_num_pkts(NUM_THREADS, NUM_LANES);
    localparam int PID_WIDTH = calc_pid_width(NUM_THREADS, NUM_LANES);
    localparam int PKT_W     = NUM_LANES * XLEN;

    state_e                              state;
    logic [PID_WIDTH-1:0]                pid_r;
    logic                                sop_r;
    logic [NUM_PKTS-1:0]                 pending_r;
    logic [HDR_W-1:0]                    hdr_r;
    logic [NUM_PKTS-1:0][NUM_LANES-1:0]  tmask_r;
    logic [NUM_PKTS-1:0][PKT_W-1:0]      rs1_r;
    logic [NUM_PKTS-1:0][PKT_W-1:0]      rs2_r;
    logic [NUM_PKTS-1:0][PKT_W-1:0]      rs3_r;

    logic [MAX_THREADS-1:0]              tmask_ext;
    logic [NUM_PKTS-1:0]                 pending_new;
    logic [NUM_PKTS-1:0]                 done_mask;
    logic [PID_WIDTH-1:0]                first_pid;
    logic                                first_any;
    logic [PID_WIDTH-1:0]                next_pid;
    logic                                has_next;

    logic                                out_valid_s;
    logic                                eop_s;
    logic                                out_fire;
    logic                                in_ready_s;
    logic                                in_fire;

    assign tmask_ext = MAX_THREADS'(bus.in_tmask);

    // Which packets of the incoming warp will be issued.
    always_comb begin
`ifdef ALU_SPLIT_SKIP_EMPTY_EN
        pending_new = NUM_PKTS'(pkt_active(tmask_ext, NUM_THREADS, NUM_LANES));
`else
        pending_new = {NUM_PKTS{(|tmask_ext) | 1'b1}};
`endif
    end

    // Packets at or below the current pid are already issued (or being issued now).
    always_comb begin
        done_mask = '0;
        for (int p = 0; p < NUM_PKTS; p++) begin
            done_mask[p] = (p <= int'(pid_r));
        end
    end

    // First packet of a newly accepted warp; an empty warp falls back to pid 0.
    alu_lane_split_prio_enc #(
        .N  (NUM_PKTS),
        .LN (PID_WIDTH)
    ) u_first_sel (
        .data_in   (pending_new),
        .index     (first_pid),
        .valid_out (first_any)
    );

    // Next packet after the current one; no candidate left means the current packet is the last.
    alu_lane_split_prio_enc #(
        .N  (NUM_PKTS),
        .LN (PID_WIDTH)
    ) u_next_sel (
        .data_in   (pending_r & ~done_mask),
        .index     (next_pid),
        .valid_out (has_next)
    );

    assign out_valid_s = (state == ISSUE);
    assign eop_s       = out_valid_s & ~has_next;
    assign out_fire    = out_valid_s & bus.out_ready;
    assign in_ready_s  = (state == IDLE) || (out_fire && eop_s);
    assign in_fire     = bus.in_valid & in_ready_s;

    // Warp latch and issue FSM; a new warp may load on the same edge the previous eop leaves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pid_r     <= '0;
            sop_r     <= 1'b0;
            pending_r <= '0;
            hdr_r     <= '0;
            tmask_r   <= '0;
            rs1_r     <= '0;
            rs2_r     <= '0;
            rs3_r     <= '0;
        end else begin
            case (state)
                IDLE, ISSUE: begin
                    if (in_fire) begin
                        hdr_r     <= bus.in_hdr;
                        tmask_r   <= bus.in_tmask;
                        rs1_r     <= bus.in_rs1_data;
                        rs2_r     <= bus.in_rs2_data;
                        rs3_r     <= bus.in_rs3_data;
                        pending_r <= pending_new;
                        pid_r     <= first_any ? first_pid : '0;
                        sop_r     <= 1'b1;
                        state     <= ISSUE;
                    end else if (out_fire) begin
                        if (eop_s) begin
                            state <= IDLE;
                        end else begin
                            pid_r <= next_pid;
                            sop_r <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_s;
    assign bus.out_hdr      = hdr_r;
    assign bus.out_tmask    = tmask_r[pid_r];
    assign bus.out_rs1_data = rs1_r[pid_r];
    assign bus.out_rs2_data = rs2_r[pid_r];
    assign bus.out_rs3_data = rs3_r[pid_r];
    assign bus.out_pid      = pid_r;
    assign bus.out_sop      = out_valid_s & sop_r;
    assign bus.out_eop      = eop_s;

endmodule

// File: tb/tb_alu_lane_split.sv
// tb/tb_alu_lane_split.sv - scoreboard bench for alu_lane_split (NUM_THREADS=8, NUM_LANES=2)
module tb_alu_lane_split;

`ifdef ALU_SPLIT_SKIP_EMPTY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [1:0]  pid;
        logic [1:0]  tmask;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] rs3;
        logic [63:0] hdr;
        logic        sop;
        logic        eop;
    } pkt_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   fire_cnt;
    pkt_t exp_q[$];

    alu_lane_split_if #(.NUM_THREADS(8), .NUM_LANES(2), .HDR_W(64), .XLEN(32)) bus ();

    alu_lane_split #(.NUM_THREADS(8), .NUM_LANES(2), .HDR_W(64), .XLEN(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference expansion of the warp currently on the input into its expected packets.
    function automatic void push_expected();
        logic inc [4];
        int   first;
        int   last;
        logic any;
        pkt_t e;
        any = 1'b0;
        for (int p = 0; p < 4; p++) begin
            inc[p] = SKIP ? (bus.in_tmask[2*p +: 2] != 2'b00) : 1'b1;
            any    = any | inc[p];
        end
        if (!any) inc[0] = 1'b1;
        first = -1;
        last  = -1;
        for (int p = 0; p < 4; p++) begin
            if (inc[p]) begin
                if (first < 0) first = p;
                last = p;
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (inc[p]) begin
                e.pid   = 2'(p);
                e.tmask = bus.in_tmask[2*p +: 2];
                e.rs1   = bus.in_rs1_data[64*p +: 64];
                e.rs2   = bus.in_rs2_data[64*p +: 64];
                e.rs3   = bus.in_rs3_data[64*p +: 64];
                e.hdr   = bus.in_hdr;
                e.sop   = (p == first);
                e.eop   = (p == last);
                exp_q.push_back(e);
            end
        end
    endfunction

    // Scoreboard: compare every fired packet, then record any warp accepted on the same edge.
    always @(negedge clk) begin
        pkt_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            fire_cnt++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pkt_unexpected: got pid=%0d tmask=%b with nothing expected", bus.out_pid, bus.out_tmask);
            end else begin
                e = exp_q.pop_front();
                if ({bus.out_pid, bus.out_tmask, bus.out_rs1_data, bus.out_rs2_data, bus.out_rs3_data,
                     bus.out_hdr, bus.out_sop, bus.out_eop} !==
                    {e.pid, e.tmask, e.rs1, e.rs2, e.rs3, e.hdr, e.sop, e.eop}) begin
                    n_fail++;
                    $display("FAIL pkt: got pid=%0d tm=%b sop=%b eop=%b rs1=%h hdr=%h, want pid=%0d tm=%b sop=%b eop=%b rs1=%h hdr=%h",
                             bus.out_pid, bus.out_tmask, bus.out_sop, bus.out_eop, bus.out_rs1_data, bus.out_hdr,
                             e.pid, e.tmask, e.sop, e.eop, e.rs1, e.hdr);
                end
            end
        end
        if (rst_n && bus.in_valid && bus.in_ready) push_expected();
    end

    task automatic drive_warp_data(input logic [7:0] tm);
        bus.in_tmask = tm;
        bus.in_hdr   = {$urandom, $urandom};
        for (int t = 0; t < 8; t++) begin
            bus.in_rs1_data[32*t +: 32] = 32'(t + 1);
            bus.in_rs2_data[32*t +: 32] = $urandom;
            bus.in_rs3_data[32*t +: 32] = $urandom;
        end
    endtask

    // Presents a warp until it is accepted; returns 1 ns after the accepting edge with in_valid low.
    task automatic send_warp(input logic [7:0] tm);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        drive_warp_data(tm);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_accept: in_ready=%b after 50 cycles, want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int want_pkts, input int start_cnt);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_drain: %0d packets still expected, out_valid=%b, want 0 and 0", name, exp_q.size(), bus.out_valid);
        end
        n_tests++;
        if (fire_cnt - start_cnt != want_pkts) begin
            n_fail++;
            $display("FAIL %s_count: %0d packets issued, want %0d", name, fire_cnt - start_cnt, want_pkts);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_warp_data(8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.out_valid, bus.out_sop, bus.out_eop} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid/sop/eop=%b, want 000", {bus.out_valid, bus.out_sop, bus.out_eop});
        end
        n_tests++;
        if ({bus.out_pid, bus.out_tmask} !== 4'h0 || bus.out_hdr !== 64'h0 || bus.out_rs1_data !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: pid=%0d tmask=%b hdr=%h rs1=%h, want all 0", bus.out_pid, bus.out_tmask, bus.out_hdr, bus.out_rs1_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 and 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_full_warp();
        int start;
        start = fire_cnt;
        send_warp(8'hFF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_pid !== 2'(i)) begin
                n_fail++;
                $display("FAIL full_seq: cycle %0d valid=%b pid=%0d, want 1 and %0d", i, bus.out_valid, bus.out_pid, i);
            end
            if (i == 2) begin
                n_tests++;
                if (bus.out_rs1_data !== {32'd6, 32'd5}) begin
                    n_fail++;
                    $display("FAIL full_rs1_pid2: got %h, want %h", bus.out_rs1_data, {32'd6, 32'd5});
                end
            end
        end
        drain("full", 4, start);
    endtask

    task automatic test_sparse();
        int start;
        start = fire_cnt;
        send_warp(8'b0011_0000);
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_pid !== (SKIP ? 2'd2 : 2'd0) || bus.out_sop !== 1'b1) begin
            n_fail++;
            $display("FAIL sparse_first: valid=%b pid=%0d sop=%b, want 1 %0d 1", bus.out_valid, bus.out_pid, bus.out_sop, SKIP ? 2 : 0);
        end
        drain("sparse", SKIP ? 1 : 4, start);
    endtask

    task automatic test_empty_mask();
        int start;
        bit seen;
        start = fire_cnt;
        seen  = 1'b0;
        send_warp(8'h00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_eop) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_eop_ready: eop seen=%b in_ready=%b, want 1 and 1", seen, bus.in_ready);
        end
        drain("empty", SKIP ? 1 : 4, start);
    endtask

    task automatic test_backpressure();
        int start;
        logic [64*4+2+2+1+1+1-1:0] snap;
        start = fire_cnt;
        send_warp(8'hFF);
        @(negedge clk);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        snap = {bus.out_hdr, bus.out_rs1_data, bus.out_rs2_data, bus.out_rs3_data,
                bus.out_tmask, bus.out_pid, bus.out_sop, bus.out_eop, bus.out_valid};
        n_tests++;
        if (bus.out_pid !== 2'd1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_enter: pid=%0d valid=%b in_ready=%b, want 1 1 0", bus.out_pid, bus.out_valid, bus.in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
            n_tests++;
            if ({bus.out_hdr, bus.out_rs1_data, bus.out_rs2_data, bus.out_rs3_data, bus.out_tmask,
                 bus.out_pid, bus.out_sop, bus.out_eop, bus.out_valid} !== snap || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d pid=%0d in_ready=%b payload changed, want pid 1 held and in_ready 0",
                         k, bus.out_pid, bus.in_ready);
            end
        end
        @(negedge clk);
        n_tests++;
        if (bus.out_pid !== 2'd2 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_resume: pid=%0d valid=%b, want 2 and 1", bus.out_pid, bus.out_valid);
        end
        drain("stall", 4, start);
    endtask

    task automatic test_back_to_back();
        int start;
        bit ok;
        start = fire_cnt;
        ok    = 1'b0;
        @(posedge clk); #1;
        drive_warp_data(8'h03);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        @(posedge clk); #1;
        drive_warp_data(8'hC0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok || bus.out_valid !== 1'b1 || bus.out_eop !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: accepted=%b valid=%b eop=%b, want second warp taken on first warp eop",
                     ok, bus.out_valid, bus.out_eop);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_sop !== 1'b1 || bus.out_pid !== (SKIP ? 2'd3 : 2'd0)) begin
            n_fail++;
            $display("FAIL b2b_no_bubble: valid=%b sop=%b pid=%0d, want 1 1 %0d", bus.out_valid, bus.out_sop, bus.out_pid, SKIP ? 3 : 0);
        end
        drain("b2b", SKIP ? 2 : 8, start);
    endtask

    task automatic test_reset_mid_warp();
        int start;
        bool_wait: begin
        end
        send_warp(8'hFF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_pid == 2'd1) break;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_pid, bus.out_tmask} !== 7'b0 || bus.out_hdr !== 64'h0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b sop=%b eop=%b pid=%0d tmask=%b hdr=%h, want all 0",
                     bus.out_valid, bus.out_sop, bus.out_eop, bus.out_pid, bus.out_tmask, bus.out_hdr);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: in_ready=%b out_valid=%b, want 1 and 0", bus.in_ready, bus.out_valid);
        end
        start = fire_cnt;
        send_warp(8'h0C);
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_sop !== 1'b1 || bus.out_pid !== (SKIP ? 2'd1 : 2'd0)) begin
            n_fail++;
            $display("FAIL reset_mid_first: valid=%b sop=%b pid=%0d, want 1 1 %0d", bus.out_valid, bus.out_sop, bus.out_pid, SKIP ? 1 : 0);
        end
        drain("reset_mid", SKIP ? 1 : 4, start);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        fire_cnt = 0;
        test_reset();
        test_full_warp();
        test_sparse();
        test_empty_mask();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_warp();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_lane_split.md
Name: alu_lane_split

Overview:
- Upstream feeder of the integer ALU block.
- Accepts one full-warp execute request (NUM_THREADS lanes) and serialises it into NUM_LANES-wide packets, each tagged with pid/sop/eop, on the execute interface the ALU consumes.
- Sits between the ALU dispatch queue and the ALU block.
- Registered output; one packet per cycle; no bubble between warps.

Parameters:
- NUM_THREADS, 8, lanes per warp on the input side.
- NUM_LANES, 2, lanes per output packet; must divide NUM_THREADS.
- HDR_W, 64, width of the opaque header (uuid, wid, PC, rd, wb, op_type, op_args), carried unchanged.
- XLEN, 32, operand width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  warp request valid.
- in_ready  out  1  warp request accepted.
- in_hdr  in  HDR_W  header.
- in_tmask  in  NUM_THREADS  thread mask.
- in_rs1_data / in_rs2_data / in_rs3_data  in  NUM_THREADS*XLEN  operands; lane t occupies bits [t*XLEN +: XLEN].
- out_valid  out  1  packet valid.
- out_ready  in  1  ALU accepts packet.
- out_hdr  out  HDR_W  copy of the latched header.
- out_tmask  out  NUM_LANES  packet lane mask.
- out_rs1_data / out_rs2_data / out_rs3_data  out  NUM_LANES*XLEN  packet operands.
- out_pid  out  PID_WIDTH  packet index, where PID_WIDTH = max(1, clog2(NUM_THREADS/NUM_LANES)).
- out_sop, out_eop  out  1  first / last packet of the warp.

Behaviour:
- NUM_PKTS = NUM_THREADS/NUM_LANES. Packet p covers lanes [p*NUM_LANES, (p+1)*NUM_LANES).
- FSM states: IDLE, ISSUE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_eop). This is a combinational path from out_ready.
- On in fire:
  - latch hdr, tmask and operands.
  - compute pending[p] = OR of the tmask slice for packet p.
  - load the first selected pid, set sop=1, and go to (or stay in) ISSUE.
  - out_valid rises the cycle after in fire (latency 1).
- In ISSUE, out_valid=1. All out_* fields are stable while out_valid && !out_ready.
- On out fire with !eop: advance pid to the next selected packet, set sop=0, and compute eop for it.
- On out fire with eop:
  - if in fire occurs in the same cycle, load the new warp with no idle cycle;
  - otherwise go to IDLE with out_valid=0.
- eop = no selected packet remains after the current pid.
- NUM_PKTS==1: a single packet with pid=0 and sop=eop=1, i.e. a pipe register.
- Reset (asynchronous, mid-operation included):
  - state=IDLE, out_valid=0, out_pid=0, out_sop=0, out_eop=0, out_tmask=0, out_hdr/out_rs*=0.
  - a partially issued warp is discarded.
  - in_ready=1 in the first cycle after release.

Optional Feature:
- Macro ALU_SPLIT_SKIP_EMPTY_EN.
- Defined:
  - only packets with pending[p]=1 are issued, in ascending pid order.
  - if tmask==0, exactly one packet is issued: pid=0, sop=eop=1, out_tmask=0, so the warp still commits.
- Undefined: all NUM_PKTS packets are issued, including packets with a zero mask slice.

Decomposition:
- VX_gpu_pkg holds:
  - PID_WIDTH and the NUM_PKTS derivation;
  - the state enum (IDLE/ISSUE);
  - a helper function that computes the per-packet "any lane active" vector from tmask.
- Sub-module: the next-pid selector is an instance of the existing VX_priority_encoder (N=NUM_PKTS) over pending & ~done-mask.
  - done-mask = bits at or below the current pid.
  - The encoder's valid_out inverted gives eop lookahead.

Test Plan (NUM_THREADS=8, NUM_LANES=2, out_ready=1 unless noted):
- tmask=8'hFF, rs1 lane t = t+1 → 4 packets over 4 consecutive cycles.
  - pid 0,1,2,3; each tmask 2'b11.
  - rs1 of pid2 = {6,5}.
  - sop only on pid0; eop only on pid3.
- tmask=8'b0011_0000, SKIP_EN defined → one packet: pid=2, tmask=2'b11, sop=eop=1. SKIP_EN undefined → 4 packets with tmasks 00,00,11,00 and eop on pid3.
- tmask=8'h00, SKIP_EN defined → one packet: pid=0, tmask=00, sop=eop=1; in_ready=1 on the eop fire cycle.
- tmask=8'hFF, out_ready=0 for 3 cycles at pid1 → pid1 payload held bit-stable; in_ready=0 throughout; pid2 follows 1 cycle after out_ready rises.
- Two warps back-to-back with in_valid held, first tmask=8'h03, second tmask=8'hC0 (SKIP_EN) → second warp accepted on the eop cycle of the first; its pid3 packet appears the next cycle with no bubble.
- reset driven low after pid1 fires → out_valid=0 asynchronously. After release, a new warp with tmask=8'h0C issues pid1 with sop=1 and no stale packets.
